// File: rtl/bcd_to_binary.sv
// Sequential reverse double-dabble: packed BCD in, unsigned binary out.
// One shift-and-correct step per clock, start/busy/done handshake.
module bcd_to_binary #(
  parameter int DIGITS    = 3,
  parameter int BIN_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_WIDTH-1:0]  bin_out,
  output logic                  error
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_WIDTH;
  localparam int CNT_W  = $clog2(BIN_WIDTH + 1);

  if ((64'd1 << BIN_WIDTH) <= 64'(10 ** DIGITS - 1)) begin : g_width_check
    $error("BIN_WIDTH cannot hold the largest DIGITS-digit decimal value");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] bcd);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | (bcd[4*i +: 4] > 4'd9);
    end
    return bad;
  endfunction

  // Shift right, then pull every BCD digit >= 8 back down by 3 (no borrow between digits).
  function automatic logic [WORK_W-1:0] shift_step(input logic [WORK_W-1:0] w);
    logic [WORK_W-1:0] s;
    s = {1'b0, w[WORK_W-1:1]};
    for (int i = 0; i < DIGITS; i++) begin
      s[BIN_WIDTH + 4*i +: 4] = (s[BIN_WIDTH + 4*i +: 4] >= 4'd8) ?
                                (s[BIN_WIDTH + 4*i +: 4] - 4'd3) :
                                s[BIN_WIDTH + 4*i +: 4];
    end
    return s;
  endfunction

  state_e                state_q, state_d;
  logic [WORK_W-1:0]     work_q, work_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [BIN_WIDTH-1:0]  bin_out_q, bin_out_d;
  logic                  error_q, error_d;

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    bin_out_d = bin_out_q;
    error_d   = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d = {bcd_in, {BIN_WIDTH{1'b0}}};
          if (has_bad_digit(bcd_in)) begin
            // Invalid digit: report straight away, never run the shifter.
            state_d   = S_DONE;
            done_d    = 1'b1;
            bin_out_d = {BIN_WIDTH{1'b0}};
            error_d   = 1'b1;
          end else begin
            state_d = S_SHIFT;
            cnt_d   = CNT_W'(BIN_WIDTH);
            busy_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        work_d = shift_step(work_q);
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          bin_out_d = work_d[BIN_WIDTH-1:0];
          error_d   = 1'b0;
        end else begin
          busy_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      work_q    <= {WORK_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bin_out_q <= {BIN_WIDTH{1'b0}};
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bin_out_q <= bin_out_d;
      error_q   <= error_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bin_out = bin_out_q;
  assign error   = error_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: stimulus pushes expected results,
// a forked monitor pops and checks them whenever done pulses.
module tb_bcd_to_binary;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] bcd_in;
  logic        busy;
  logic        done;
  logic [9:0]  bin_out;
  logic        error;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [9:0] bin;
    logic       err;
    int         cyc;
    int         busy;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  bcd_to_binary #(.DIGITS(3), .BIN_WIDTH(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .error   (error)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called right after a negedge on which start is being presented.
  task automatic push(input logic [9:0] b, input logic e);
    exp_t x;
    x.bin  = b;
    x.err  = e;
    x.cyc  = cyc + 1 + (e ? 0 : 10);
    x.busy = e ? 0 : 10;
    sb.push_back(x);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic convert(input logic [11:0] b, input logic [9:0] v, input logic e);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = b;
    push(v, e);
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 12'hABC;
    wait_drain();
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    bcd_in = 12'h000;

    fork
      begin : monitor
        int   busy_run;
        exp_t e;
        busy_run = 0;
        forever begin
          @(negedge clk);
          if (busy) begin
            busy_run++;
          end else if (done) begin
            if (sb.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_done: got done=1 bin_out=%0d expected no done (cycle %0d)",
                       bin_out, cyc);
            end else begin
              e = sb.pop_front();
              chk("bin_out",     int'(bin_out), int'(e.bin));
              chk("error",       int'(error),   int'(e.err));
              chk("latency",     cyc,           e.cyc);
              chk("busy_cycles", busy_run,      e.busy);
            end
            busy_run = 0;
          end else begin
            busy_run = 0;
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("reset_busy",    int'(busy),    0);
    chk("reset_done",    int'(done),    0);
    chk("reset_bin_out", int'(bin_out), 0);
    chk("reset_error",   int'(error),   0);
    reset = 1'b0;

    convert(12'h999, 10'd999, 1'b0);

    // start held high: three conversions back to back, bcd_in changed during each DONE-then-IDLE gap
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h000;
    push(10'd0, 1'b0);
    repeat (12) @(negedge clk);
    bcd_in = 12'h255;
    push(10'd255, 1'b0);
    repeat (12) @(negedge clk);
    bcd_in = 12'h100;
    push(10'd100, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    convert(12'h1A3, 10'd0, 1'b1);
    convert(12'h042, 10'd42, 1'b0);
    convert(12'h9F0, 10'd0, 1'b1);
    convert(12'h980, 10'd980, 1'b0);

    // Second start mid-conversion must be ignored
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h321;
    push(10'd321, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h777;
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // Reset mid-conversion: aborted result never reported
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h500;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy",    int'(busy),    0);
    chk("abort_done",    int'(done),    0);
    chk("abort_bin_out", int'(bin_out), 0);
    chk("abort_error",   int'(error),   0);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    convert(12'h500, 10'd500, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      logic [11:0] b;
      b = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
      convert(b, 10'(i), 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
